// File: rtl/alu_pc_stage_if.sv
// Operand/control bundle into the ALU/PC stage and its result/state outputs.
// Master drives srca/srcb/controls; slave (the stage) drives the results.
interface alu_pc_stage_if #(
   parameter int unsigned WIDTH = 64
);
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic [2:0]       alu_control;
   logic             pc_en;
   logic             pc_src;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] pc;

   modport master (
      output srca, srcb, alu_control,
      output pc_en, pc_src,
      input  result, zero, ovf,
      input  alu_out, pc
   );

   modport slave (
      input  srca, srcb, alu_control,
      input  pc_en, pc_src,
      output result, zero, ovf,
      output alu_out, pc
   );
endinterface

// File: rtl/alu_pc_stage.sv
// Multi-cycle MIPS execute stage: ALU, ALUOut register and enabled PC.
// Define ALU_OVERFLOW_EN to build signed ADD/SUB overflow detection.
module alu_pc_stage #(
   parameter int unsigned      WIDTH    = 64,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           reset,
   alu_pc_stage_if.slave io
);
   logic [WIDTH-1:0] a, b, bb, sum;
   logic [WIDTH-1:0] result, next_pc;
   logic [WIDTH-1:0] alu_out_d, alu_out_q;
   logic [WIDTH-1:0] pc_d, pc_q;
   logic [2:0]       op;
   logic             slt;

   assign a  = io.srca;
   assign b  = io.srcb;
   assign op = io.alu_control;

   // op[2] inverts B; with carry-in it turns the adder into a subtractor
   assign bb  = op[2] ? ~b : b;
   assign sum = a + bb + {{(WIDTH-1){1'b0}}, op[2]};
   assign slt = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      unique case (op[1:0])
         2'b00: result = a & bb;
         2'b01: result = a | bb;
         2'b10: result = sum;
         2'b11: result = {{(WIDTH-1){1'b0}}, op[2] & slt};
      endcase
   end

   assign next_pc = io.pc_src ? alu_out_q : result;

   always_comb begin
      alu_out_d = result;
      pc_d      = pc_q;
      if (io.pc_en) pc_d = next_pc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_out_q <= '0;
         pc_q      <= RESET_PC;
      end else begin
         alu_out_q <= alu_out_d;
         pc_q      <= pc_d;
      end
   end

   assign io.result  = result;
   assign io.zero    = ~|result;
   assign io.alu_out = alu_out_q;
   assign io.pc      = pc_q;

`ifdef ALU_OVERFLOW_EN
   // same-sign effective operands whose sum flips sign
   assign io.ovf = (op[1:0] == 2'b10)
                 & (a[WIDTH-1] == bb[WIDTH-1])
                 & (sum[WIDTH-1] != a[WIDTH-1]);
`else
   assign io.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pc_stage.sv
// Self-checking bench for alu_pc_stage: vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_alu_pc_stage;
   localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = '1;

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [63:0] m_alu, m_pc, m_res;

   alu_pc_stage_if #(.WIDTH(64)) bus ();

   alu_pc_stage #(.WIDTH(64), .RESET_PC('0)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   always #5 if (clk_run) clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
      logic [63:0] r;
      logic        z;
      logic        v;
   } vec_t;

   vec_t tbl[16];

`ifdef ALU_OVERFLOW_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_alu(
      input logic [63:0] a, b, input logic [2:0] op);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd3: return 64'd0;
         3'd4: return a & ~b;
         3'd5: return a | ~b;
         3'd6: return a - b;
         default: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      endcase
   endfunction

   // Overflow from the exact 65-bit signed result leaving 64-bit range
   function automatic logic ref_ovf(
      input logic [63:0] a, b, input logic [2:0] op);
      logic signed [64:0] w;
      if (!OVF_ON) return 1'b0;
      if (op == 3'd2) w = $signed({a[63], a}) + $signed({b[63], b});
      else if (op == 3'd6) w = $signed({a[63], a}) - $signed({b[63], b});
      else return 1'b0;
      return w[64] != w[63];
   endfunction

   task automatic drive(input logic [63:0] a, b, input logic [2:0] op,
                        input logic en, src);
      bus.srca        = a;
      bus.srcb        = b;
      bus.alu_control = op;
      bus.pc_en       = en;
      bus.pc_src      = src;
   endtask

   // One cycle: drive after negedge, check comb, clock, check registers
   task automatic step(input logic [63:0] a, b, input logic [2:0] op,
                       input logic en, src, input string tag);
      @(negedge clk);
      drive(a, b, op, en, src);
      #1;
      m_res = ref_alu(a, b, op);
      chk({tag, ".result"}, bus.result, m_res);
      chk({tag, ".zero"}, {63'd0, bus.zero}, {63'd0, m_res == 0});
      chk({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, ref_ovf(a, b, op)});
      @(posedge clk);
      if (!reset) begin
         if (en) m_pc = src ? m_alu : m_res;
         m_alu = m_res;
      end
      #1;
      chk({tag, ".alu_out"}, bus.alu_out, m_alu);
      chk({tag, ".pc"}, bus.pc, m_pc);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [63:0] sp[4];
      sp[0] = MAX; sp[1] = MIN; sp[2] = ONES; sp[3] = 64'd0;

      tbl[0]  = '{64'd5, 64'd3, 3'b010, 64'd8, 1'b0, 1'b0};
      tbl[1]  = '{64'd5, 64'd3, 3'b110, 64'd2, 1'b0, 1'b0};
      tbl[2]  = '{64'd5, 64'd3, 3'b000, 64'd1, 1'b0, 1'b0};
      tbl[3]  = '{64'd5, 64'd3, 3'b001, 64'd7, 1'b0, 1'b0};
      tbl[4]  = '{64'd5, 64'd3, 3'b100, 64'd4, 1'b0, 1'b0};
      tbl[5]  = '{64'd5, 64'd3, 3'b111, 64'd0, 1'b1, 1'b0};
      tbl[6]  = '{64'd5, 64'd3, 3'b011, 64'd0, 1'b1, 1'b0};
      tbl[7]  = '{64'd5, 64'd3, 3'b101,
                  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
      tbl[8]  = '{ONES, 64'd1, 3'b111, 64'd1, 1'b0, 1'b0};
      tbl[9]  = '{64'd1, ONES, 3'b111, 64'd0, 1'b1, 1'b0};
      tbl[10] = '{MIN, 64'd1, 3'b111, 64'd1, 1'b0, 1'b0};
      tbl[11] = '{64'd4, 64'd4, 3'b110, 64'd0, 1'b1, 1'b0};
      tbl[12] = '{MAX, 64'd1, 3'b010, MIN, 1'b0, 1'b1};
      tbl[13] = '{MIN, 64'd1, 3'b110, MAX, 1'b0, 1'b1};
      tbl[14] = '{MIN, 64'd1, 3'b000, 64'd0, 1'b1, 1'b0};
      tbl[15] = '{MAX, ONES, 3'b111, 64'd0, 1'b1, 1'b0};

      drive(64'd0, 64'd0, 3'b000, 1'b0, 1'b0);

      // Async reset with the clock stopped
      #2 reset = 1'b1;
      #1;
      chk("rst_noclk.alu_out", bus.alu_out, 64'd0);
      chk("rst_noclk.pc", bus.pc, 64'd0);
      #1 reset = 1'b0;
      m_alu = '0;
      m_pc  = '0;
      clk_run = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, 1'b0);
         #1;
         chk($sformatf("tbl%0d.result", i), bus.result, tbl[i].r);
         chk($sformatf("tbl%0d.zero", i),
             {63'd0, bus.zero}, {63'd0, tbl[i].z});
         chk($sformatf("tbl%0d.ovf", i),
             {63'd0, bus.ovf}, {63'd0, tbl[i].v & OVF_ON});
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d.alu_out", i), bus.alu_out, tbl[i].r);
         chk($sformatf("tbl%0d.pc", i), bus.pc, 64'd0);
      end
      m_alu = tbl[15].r;

      // PC increment sequence, then hold while alu_out moves
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive(64'(4 * (k - 1)), 64'd4, 3'b010, 1'b1, 1'b0);
         @(posedge clk);
         #1;
         chk($sformatf("inc%0d.pc", k), bus.pc, 64'(4 * k));
      end
      m_pc  = 64'd12;
      m_alu = 64'd12;
      step(64'd100, 64'd1, 3'b010, 1'b0, 1'b0, "hold1");
      step(64'd200, 64'd7, 3'b110, 1'b0, 1'b0, "hold2");
      chk("hold.pc12", bus.pc, 64'd12);

      // pc_src=1 takes the old alu_out (193) not the new result
      step(64'd1000, 64'd1, 3'b010, 1'b1, 1'b1, "oldalu");
      chk("oldalu.pc193", bus.pc, 64'd193);
      chk("oldalu.alu1001", bus.alu_out, 64'd1001);

      // Reset mid-operation while the clock runs and pc_en=1
      @(negedge clk);
      drive(64'd77, 64'd3, 3'b010, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("midrst.alu_out", bus.alu_out, 64'd0);
      chk("midrst.pc", bus.pc, 64'd0);
      @(posedge clk);
      #1;
      chk("rsthold.alu_out", bus.alu_out, 64'd0);
      chk("rsthold.pc", bus.pc, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      m_alu = '0;
      m_pc  = '0;
      step(64'd40, 64'd2, 3'b010, 1'b1, 1'b0, "postrst");

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = sp[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) rb = sp[$urandom_range(0, 3)];
         if ($urandom_range(0, 7) == 0) rb = ra;
         step(ra, rb, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
